// File: rtl/pio_mem_writer_if.sv
// Nios PIO command inputs and RAM write-port/status outputs of the PIO memory writer.
// master = software/PIO side, slave = the write sequencer.
interface pio_mem_writer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pio_address;
  logic [DATA_W-1:0] pio_data;
  logic [ADDR_W-1:0] pio_count;
  logic [2:0]        pio_ctrl;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic              busy;
  logic              overflow;
  logic [7:0]        status;

  modport master (
    output pio_address, pio_data, pio_count, pio_ctrl,
    input  mem_address, mem_data, mem_wren, busy, overflow, status
  );

  modport slave (
    input  pio_address, pio_data, pio_count, pio_ctrl,
    output mem_address, mem_data, mem_wren, busy, overflow, status
  );
endinterface

// File: rtl/pio_mem_writer.sv
// Turns Nios PIO strobes into single or burst-fill RAM write cycles,
// decoupled from software through a small command FIFO.
module pio_mem_writer #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  pio_mem_writer_if.slave  bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, FILL = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              strobe_q;
  logic              overflow_q, overflow_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_cnt_q  [FIFO_DEPTH];
  logic              fifo_fill_q [FIFO_DEPTH];

  logic push_req, full, empty, push, drop, pop;
  logic [2:0] level3;

  // Fullness comes from the registered level, so a same-edge pop never rescues a push.
  assign push_req = bus.pio_ctrl[0] & ~strobe_q;
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = push_req & ~full;
  assign drop     = push_req & full;
  assign pop      = (state_q == IDLE) & ~empty;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop)
      overflow_d = 1'b1;
    else if (bus.pio_ctrl[2])
      overflow_d = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = wren_q;
    remain_d = remain_q;
    case (state_q)
      IDLE: begin
        wren_d = 1'b0;
        if (pop) begin
          addr_d = fifo_addr_q[rd_ptr_q];
          data_d = fifo_data_q[rd_ptr_q];
          if (!fifo_fill_q[rd_ptr_q]) begin
            wren_d  = 1'b1;
            state_d = WRITE;
          end else if (fifo_cnt_q[rd_ptr_q] != '0) begin
            remain_d = fifo_cnt_q[rd_ptr_q];
            wren_d   = 1'b1;
            state_d  = FILL;
          end
        end
      end
      WRITE: begin
        wren_d  = 1'b0;
        state_d = IDLE;
      end
      FILL: begin
        remain_d = remain_q - 1'b1;
        if (remain_q == ADDR_W'(1)) begin
          wren_d  = 1'b0;
          state_d = IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        wren_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // strobe_q resets high so a strobe held through reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      strobe_q   <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      remain_q   <= '0;
    end else begin
      state_q    <= state_d;
      strobe_q   <= bus.pio_ctrl[0];
      overflow_q <= overflow_d;
      level_q    <= level_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      remain_q   <= remain_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.pio_address;
      fifo_data_q[wr_ptr_q] <= bus.pio_data;
      fifo_cnt_q[wr_ptr_q]  <= bus.pio_count;
      fifo_fill_q[wr_ptr_q] <= bus.pio_ctrl[1];
    end
  end

  generate
    if (LVL_W >= 3) begin : g_lvl_trunc
      assign level3 = level_q[2:0];
    end else begin : g_lvl_pad
      assign level3 = {{(3 - LVL_W){1'b0}}, level_q};
    end
  endgenerate

  assign bus.mem_address = addr_q;
  assign bus.mem_data    = data_q;
  assign bus.mem_wren    = wren_q;
  assign bus.busy        = ~empty | (state_q != IDLE);
  assign bus.overflow    = overflow_q;
  assign bus.status      = {overflow_q, bus.busy, level3, 1'b0, state_q};
endmodule

// File: tb/tb_pio_mem_writer.sv
// Directed bench for pio_mem_writer: reset/strobe, single write, wrapping fill,
// overflow handling and reset during a fill.
module tb_pio_mem_writer;
  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pio_mem_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pio_mem_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [ADDR_W-1:0] wa_q [$];
  logic [DATA_W-1:0] wd_q [$];
  int                wc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_wren === 1'b1) begin
      wa_q.push_back(bus.mem_address);
      wd_q.push_back(bus.mem_data);
      wc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic set_pio(input logic [11:0] a, input logic [15:0] d,
                         input logic [11:0] c, input logic [2:0] ctrl);
    bus.pio_address = a;
    bus.pio_data    = d;
    bus.pio_count   = c;
    bus.pio_ctrl    = ctrl;
  endtask

  // one strobe: high for one edge, low for one edge
  task automatic strobe(input logic [11:0] a, input logic [15:0] d,
                        input logic [11:0] c, input logic [2:0] ctrl);
    set_pio(a, d, c, ctrl);
    tick();
    bus.pio_ctrl = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_pio(12'h5A5, 16'h1234, 12'h003, 3'b001);
    repeat (3) tick();
    reset = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.mem_wren !== 1'b0 || bus.status !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d wren=%b status=%h expected wren=0 status=00", i, bus.mem_wren, bus.status);
      end
    end
    checks++;
    if (bus.mem_address !== 12'h000 || bus.mem_data !== 16'h0000 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs addr=%h data=%h busy=%b ovf=%b expected all 0", bus.mem_address, bus.mem_data, bus.busy, bus.overflow);
    end
    bus.pio_ctrl = 3'b000;
    repeat (3) tick();
    checks++;
    if (wa_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_write writes=%0d expected 0", wa_q.size());
    end
  endtask

  task automatic test_single();
    set_pio(12'h123, 16'hBEEF, 12'h007, 3'b001);
    tick();
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.status !== 8'h48) begin
      errors++;
      $display("FAIL single_push wren=%b status=%h expected wren=0 status=48", bus.mem_wren, bus.status);
    end
    set_pio(12'h777, 16'h0000, 12'h000, 3'b000);
    tick();
    checks++;
    if (bus.mem_wren !== 1'b1 || bus.mem_address !== 12'h123 || bus.mem_data !== 16'hBEEF || bus.status !== 8'h41) begin
      errors++;
      $display("FAIL single_write wren=%b addr=%h data=%h status=%h expected 1 123 BEEF 41",
               bus.mem_wren, bus.mem_address, bus.mem_data, bus.status);
    end
    tick();
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.busy !== 1'b0 || bus.status !== 8'h00) begin
      errors++;
      $display("FAIL single_done wren=%b busy=%b status=%h expected 0 0 00", bus.mem_wren, bus.busy, bus.status);
    end
    clear_log();
    set_pio(12'h0AB, 16'h1234, 12'h000, 3'b001);
    repeat (8) tick();
    bus.pio_ctrl = 3'b000;
    repeat (2) tick();
    checks++;
    if (wa_q.size() != 1 || (wa_q.size() == 1 && wa_q[0] !== 12'h0AB)) begin
      errors++;
      $display("FAIL strobe_held writes=%0d expected exactly 1 write to 0ab", wa_q.size());
    end
  endtask

  task automatic test_fill_wrap();
    logic [11:0] ea;
    clear_log();
    set_pio(12'hFFE, 16'h00AA, 12'd4, 3'b011);
    tick();
    bus.pio_ctrl = 3'b000;
    tick();
    checks++;
    if (bus.status[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL fill_state state=%0d expected 2", bus.status[1:0]);
    end
    for (int i = 0; i < 4; i++) begin
      ea = 12'(12'hFFE + i);
      checks++;
      if (bus.mem_wren !== 1'b1 || bus.mem_address !== ea || bus.mem_data !== 16'h00AA) begin
        errors++;
        $display("FAIL fill_word%0d wren=%b addr=%h data=%h expected 1 %h 00aa", i, bus.mem_wren, bus.mem_address, bus.mem_data, ea);
      end
      tick();
    end
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.busy !== 1'b0 || bus.status !== 8'h00) begin
      errors++;
      $display("FAIL fill_end wren=%b busy=%b status=%h expected 0 0 00", bus.mem_wren, bus.busy, bus.status);
    end
    clear_log();
    set_pio(12'h050, 16'h5555, 12'd0, 3'b011);
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fill0_busy busy=%b expected 1", bus.busy);
    end
    bus.pio_ctrl = 3'b000;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_wren !== 1'b0) begin
      errors++;
      $display("FAIL fill0_consumed busy=%b wren=%b expected 0 0", bus.busy, bus.mem_wren);
    end
    repeat (3) tick();
    checks++;
    if (wa_q.size() != 0) begin
      errors++;
      $display("FAIL fill0_no_write writes=%0d expected 0", wa_q.size());
    end
  endtask

  task automatic test_overflow();
    int n;
    int bad;
    // Phase 1: long fill, four queued singles, fifth dropped
    clear_log();
    strobe(12'h200, 16'h1111, 12'd100, 3'b011);
    for (int i = 0; i < 4; i++) strobe(12'(12'h010 + i), 16'(16'hA000 + i), 12'd0, 3'b001);
    checks++;
    if (bus.status[5:3] !== 3'd4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_level level=%0d ovf=%b expected 4 0", bus.status[5:3], bus.overflow);
    end
    set_pio(12'h0EE, 16'hDEAD, 12'd0, 3'b001);
    tick();
    checks++;
    if (bus.overflow !== 1'b1 || bus.status[7] !== 1'b1 || bus.status[5:3] !== 3'd4) begin
      errors++;
      $display("FAIL ovf_drop ovf=%b status=%h expected ovf=1 level=4", bus.overflow, bus.status);
    end
    bus.pio_ctrl = 3'b000;
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain busy=%b after %0d cycles expected 0", bus.busy, n);
    end
    checks++;
    if (wa_q.size() != 104) begin
      errors++;
      $display("FAIL ovf_count writes=%0d expected 104", wa_q.size());
    end
    if (wa_q.size() >= 104) begin
      bad = 0;
      for (int i = 0; i < 100; i++) begin
        if (wa_q[i] !== 12'(12'h200 + i) || wd_q[i] !== 16'h1111) bad++;
        if (i > 0 && wc_q[i] - wc_q[i-1] != 1) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL ovf_fill_seq bad=%0d expected 0", bad);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa_q[100+i] !== 12'(12'h010 + i) || wd_q[100+i] !== 16'(16'hA000 + i) || wc_q[100+i] - wc_q[99+i] != 2) begin
          errors++;
          $display("FAIL ovf_single%0d addr=%h data=%h gap=%0d expected %h %h 2", i, wa_q[100+i], wd_q[100+i],
                   wc_q[100+i] - wc_q[99+i], 12'(12'h010 + i), 16'(16'hA000 + i));
        end
      end
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky ovf=%b expected 1", bus.overflow);
    end
    bus.pio_ctrl = 3'b100;
    tick();
    bus.pio_ctrl = 3'b000;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b expected 0", bus.overflow);
    end
    tick();

    // Phase 2: set beats clear; full checked before the same-edge pop
    clear_log();
    strobe(12'h400, 16'h2222, 12'd40, 3'b011);
    for (int i = 0; i < 4; i++) strobe(12'(12'h020 + i), 16'(16'hB000 + i), 12'd0, 3'b001);
    set_pio(12'h0EE, 16'hDEAD, 12'd0, 3'b101);
    tick();
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set_wins ovf=%b expected 1", bus.overflow);
    end
    bus.pio_ctrl = 3'b100;
    tick();
    bus.pio_ctrl = 3'b000;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear2 ovf=%b expected 0", bus.overflow);
    end
    n = 0;
    while (bus.mem_wren === 1'b1 && n < 100) begin tick(); n++; end
    set_pio(12'h0DD, 16'hBAD0, 12'd0, 3'b001);
    tick();
    bus.pio_ctrl = 3'b000;
    checks++;
    if (bus.overflow !== 1'b1 || bus.status[5:3] !== 3'd3) begin
      errors++;
      $display("FAIL ovf_full_on_pop ovf=%b level=%0d expected 1 3", bus.overflow, bus.status[5:3]);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin tick(); n++; end
    checks++;
    if (wa_q.size() != 44) begin
      errors++;
      $display("FAIL ovf2_count writes=%0d expected 44", wa_q.size());
    end
    bad = 0;
    foreach (wa_q[i]) if (wa_q[i] === 12'h0EE || wa_q[i] === 12'h0DD) bad++;
    if (wa_q.size() >= 44)
      for (int i = 0; i < 4; i++) if (wa_q[40+i] !== 12'(12'h020 + i) || wd_q[40+i] !== 16'(16'hB000 + i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ovf2_order bad=%0d expected 0", bad);
    end
    bus.pio_ctrl = 3'b100;
    tick();
    bus.pio_ctrl = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    clear_log();
    strobe(12'h300, 16'h5555, 12'd50, 3'b011);
    strobe(12'h030, 16'hC000, 12'd0, 3'b001);
    strobe(12'h031, 16'hC001, 12'd0, 3'b001);
    repeat (5) tick();
    checks++;
    if (bus.mem_wren !== 1'b1 || bus.status[5:3] !== 3'd2 || wa_q.size() != 9) begin
      errors++;
      $display("FAIL midfill_pre wren=%b level=%0d writes=%0d expected 1 2 9", bus.mem_wren, bus.status[5:3], wa_q.size());
    end
    reset = 1'b1;
    tick();
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.status !== 8'h00 || bus.mem_address !== 12'h000) begin
      errors++;
      $display("FAIL midfill_reset wren=%b status=%h addr=%h expected 0 00 000", bus.mem_wren, bus.status, bus.mem_address);
    end
    reset = 1'b0;
    clear_log();
    repeat (60) tick();
    checks++;
    if (wa_q.size() != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midfill_after writes=%0d busy=%b expected 0 0", wa_q.size(), bus.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_pio(12'h000, 16'h0000, 12'h000, 3'b000);
    test_reset();
    test_single();
    test_fill_wrap();
    test_overflow();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pio_mem_writer.md
# pio_mem_writer

Write sequencer that sits directly downstream of the Nios write-address output PIO. It captures the 12-bit write address, a write-data word and a control word, all driven by Nios PIO ports, and turns each software strobe into clean single-cycle or burst-fill write cycles on the write port of an on-chip dual-port RAM. A 4-entry command FIFO decouples software strobes from memory timing. A status word is returned for a Nios input PIO.

## Interface
- ADDR_W, 12: width of write address and fill count; the memory holds 2^ADDR_W words.
- DATA_W, 16: write data width.
- FIFO_DEPTH, 4: command FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- pio_address  in  ADDR_W  start address, driven from the write-address PIO out_port.
- pio_data  in  DATA_W  write or fill data, driven from the data PIO.
- pio_count  in  ADDR_W  fill length in words; ignored for single writes.
- pio_ctrl  in  3  bit0 strobe, bit1 fill mode, bit2 overflow clear.
- mem_address  out  ADDR_W  RAM write address, registered.
- mem_data  out  DATA_W  RAM write data, registered.
- mem_wren  out  1  RAM write enable, registered.
- busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE.
- overflow  out  1  sticky flag; set when a command is dropped.
- status  out  8  {overflow, busy, fifo_level[2:0], 1'b0, state[1:0]}; upper level bits are zero-padded.

## Operation
- **Strobe detect**
  - strobe_d registers pio_ctrl[0].
  - A push request occurs on an edge where pio_ctrl[0]=1 and strobe_d=0.
  - Holding the strobe high produces exactly one request.
- **Push**
  - If the FIFO is not full, push {pio_address, pio_data, pio_count, pio_ctrl[1]}.
  - If the FIFO is full, drop the command and set overflow.
  - Fullness is evaluated before any same-edge pop, so a push to a full FIFO is dropped even if a pop occurs on that edge.
- **Overflow**
  - Cleared on any edge where pio_ctrl[2]=1.
  - If set and clear occur on the same edge, set wins.
- **FSM states**: IDLE=0, WRITE=1, FILL=2.
- **IDLE**
  - If the FIFO is non-empty, pop and load mem_address/mem_data from the entry.
  - Single write (fill=0): go to WRITE with mem_wren=1.
  - Fill with count≠0: load remaining=count, set mem_wren=1, go to FILL.
  - Fill with count=0: no write, stay in IDLE; the command is consumed.
- **WRITE**
  - Next edge: mem_wren=0, go to IDLE.
- **FILL**
  - Each edge: decrement remaining.
  - If remaining was 1: mem_wren=0, go to IDLE.
  - Otherwise: mem_address increments modulo 2^ADDR_W, wrapping from 0xFFF to 0x000; mem_data is held.
- **Push/pop**: simultaneous push and pop on a non-full FIFO is legal; fifo_level is unchanged.
- **FIFO order**: commands execute strictly in FIFO order.
- **Mid-command changes**: PIO input changes during a command do not affect it; they are captured only at push.

## Timing
- **Reset values**:
  - Outputs: mem_address=0, mem_data=0, mem_wren=0, busy=0, overflow=0, status=0.
  - Internal: FIFO empty, state IDLE.
  - strobe_d resets to 1, so a strobe held high through reset produces no command.
- **Reset mid-operation**: any active write or fill aborts at that edge, the FIFO is flushed, and mem_wren=0 on the next cycle.
- **Latency**:
  - Strobe first sampled high at edge T → pushed at T.
  - Popped at T+1 → mem_wren high during cycle T+1..T+2.
- **Single write**: mem_wren is high for exactly one cycle.
- **Fill of N**: mem_wren is high for N consecutive cycles with addresses A..A+N-1 (mod 2^ADDR_W).
- **Command spacing**: at least one mem_wren-low cycle separates consecutive commands, because the pop happens only in IDLE.
- **Drain time**: back-to-back single writes drain at one write per 2 cycles.
- **busy**:
  - Rises the cycle after the push edge.
  - Falls the cycle after the FSM returns to IDLE with the FIFO empty.

## Test plan
- **Reset/strobe**: reset with pio_ctrl=001 held, then release → no mem_wren; all outputs 0; status=0.
- **Single write**: addr=0x123, data=0xBEEF, strobe pulse at T → mem_wren=1 only in cycle T+1, mem_address=0x123, mem_data=0xBEEF; busy low by T+3.
- **Wrapping fill**: addr=0xFFE, count=4, data=0x00AA → four consecutive writes to 0xFFE, 0xFFF, 0x000, 0x001; count=0 fill produces no write and busy clears.
- **Overflow**: start a count=100 fill, then issue 5 single-write strobes → first 4 queued with fifo_level=4, 5th dropped, overflow=1; 4 writes follow the fill in order. Then pio_ctrl[2] pulse → overflow=0. Clear coincident with a drop → overflow stays 1.
- **Reset mid-fill**: reset at fill cycle 10 of 50 with 2 queued entries → mem_wren=0 next cycle, fifo_level=0, no further writes after reset release.
